ysyx_24070017_ifu: RTL and testbench

Instruction fetch unit for the ysyx_24070017 core. Holds the architectural PC, issues one instruction-memory read at a time over a valid/ready request channel, and buffers the returned instruction word. It presents {pc, inst} to the decode stage (ysyx_24070017_IDU) through a valid/ready handshake. The execute stage can redirect the PC on a taken branch, jump or trap; the unit then squashes any fetch already in flight.

---
 rtl/ysyx_24070017_pkg.sv | 23 ++
 rtl/ysyx_24070017_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_24070017_ifu.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24070017_pkg.sv
// Shared types and constants for the ysyx_24070017 instruction fetch unit.
package ysyx_24070017_pkg;

    typedef logic [31:0] ysyx_24070017_WORD_TYPE;

    localparam ysyx_24070017_WORD_TYPE RESET_PC_DEFAULT = 32'h8000_0000;
    localparam ysyx_24070017_WORD_TYPE NOP_INST         = 32'h0000_0013;

    localparam logic [1:0] FETCH_ERR_OK       = 2'b00;
    localparam logic [1:0] FETCH_ERR_ACCESS   = 2'b01;
    localparam logic [1:0] FETCH_ERR_MISALIGN = 2'b10;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    function automatic logic is_misaligned(input ysyx_24070017_WORD_TYPE pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24070017_ifu.sv
// Instruction fetch unit: one outstanding imem read, single-entry output buffer
// toward IDU, PC redirect from EXU with squash of any in-flight fetch.
module ysyx_24070017_ifu
    import ysyx_24070017_pkg::*;
#(
    parameter ysyx_24070017_WORD_TYPE RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [1:0]  out_err
);

    ifu_state_e             state_q, state_d;
    ysyx_24070017_WORD_TYPE pc_q, pc_d;
    logic                   drop_q, drop_d;
    ysyx_24070017_WORD_TYPE opc_q, opc_d;
    ysyx_24070017_WORD_TYPE inst_q, inst_d;
    logic [1:0]             err_q, err_d;

    logic req_fire;

    // A misaligned PC never reaches memory; the request line is also held low in reset.
    assign imem_req_valid = rst_n && (state_q == ST_REQ) && !is_misaligned(pc_q);
    assign imem_req_addr  = {pc_q[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = (state_q == ST_HOLD);
    assign out_pc    = opc_q;
    assign out_inst  = inst_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        opc_d   = opc_q;
        inst_d  = inst_q;
        err_d   = err_q;

        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (req_fire) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (is_misaligned(pc_q)) begin
                    opc_d   = pc_q;
                    inst_d  = NOP_INST;
                    err_d   = FETCH_ERR_MISALIGN;
                    state_d = ST_HOLD;
                end else if (req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) pc_d = redirect_pc;
                // A redirect coinciding with the response squashes that response too.
                if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = ST_REQ;
                    end else begin
                        opc_d   = pc_q;
                        inst_d  = imem_resp_data;
                        err_d   = imem_resp_err ? FETCH_ERR_ACCESS : FETCH_ERR_OK;
                        state_d = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            opc_q   <= '0;
            inst_q  <= '0;
            err_q   <= FETCH_ERR_OK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            opc_q   <= opc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// Bench for ysyx_24070017_ifu: directed scenarios plus a randomized run, all
// checked against a PC-level reference model and a responding memory model.
module tb_ysyx_24070017_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  out_err;

    ysyx_24070017_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_err        (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rel_cyc = 0;

    // Handshake and request logs
    int          hs_n = 0;
    logic [31:0] hs_pc[$];
    logic [31:0] hs_inst[$];
    logic [1:0]  hs_err[$];
    int          hs_cyc[$];
    int          fire_n = 0;
    logic [31:0] fire_addr[$];

    // Memory behaviour knobs
    bit          rand_ready  = 0;
    bit          ready_force = 0;
    int          lat_lo      = 0;
    int          lat_hi      = 0;
    bit          stray_en    = 0;
    bit          ovr         = 0;
    bit          err_mode    = 0;
    bit          rand_err    = 0;
    logic [31:0] err_addr    = 32'h0;
    bit          mem_busy    = 0;
    bit          seen_deadbeef = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (err_mode && a == err_addr) || (rand_err && a[5:2] == 4'hB);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: samples acceptance at negedge, answers after lat cycles with a one-cycle pulse.
    initial begin
        bit          fire;
        bit          pend;
        bit          real_resp;
        int          cnt;
        logic [31:0] paddr;
        pend = 0; cnt = 0; paddr = 0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            fire = rst_n && imem_req_valid && imem_req_ready;
            if (fire) begin
                fire_addr.push_back(imem_req_addr);
                fire_n++;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            imem_resp_data  = $urandom;
            real_resp       = 0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (fire) begin
                    pend  = 1;
                    paddr = imem_req_addr;
                    cnt   = $urandom_range(lat_hi, lat_lo);
                end
                if (pend) begin
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = ovr ? 32'hDEAD_BEEF : mem_data(paddr);
                        imem_resp_err   = mem_err(paddr);
                        ovr       = 0;
                        pend      = 0;
                        real_resp = 1;
                    end else begin
                        cnt--;
                    end
                end else if (stray_en && $urandom_range(0, 7) == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_err   = 1'($urandom_range(0, 1));
                end
            end
            mem_busy = pend || real_resp;
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Reference model: the architectural PC is the only state; whatever the unit
    // shows or requests must correspond to it.
    initial begin
        logic [31:0] m_pc;
        logic [31:0] e_inst;
        logic [1:0]  e_err;
        bit p_ov, p_or, p_rd, p_rst;
        int idle;
        m_pc = 32'h8000_0000;
        p_ov = 0; p_or = 0; p_rd = 0; p_rst = 0; idle = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_pc = 32'h8000_0000;
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_req_addr", imem_req_addr, 32'h8000_0000);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_pc", out_pc, 32'd0);
                check("rst_out_inst", out_inst, 32'd0);
                check("rst_out_err", 32'(out_err), 32'd0);
                p_ov = 0; p_or = 0; p_rd = 0; idle = 0;
            end else begin
                if (!p_rst) rel_cyc = cyc;
                if (p_ov && !p_or && !p_rd) check("stall_keeps_valid", 32'(out_valid), 32'd1);
                if (p_ov && p_rd) check("redirect_drops_valid", 32'(out_valid), 32'd0);
                if (m_pc[1:0] != 2'b00) begin
                    check("misaligned_no_req", 32'(imem_req_valid), 32'd0);
                end else if (imem_req_valid) begin
                    check("req_addr", imem_req_addr, m_pc);
                    check("single_outstanding", 32'(mem_busy), 32'd0);
                end
                if (out_valid) begin
                    idle = 0;
                    if (m_pc[1:0] != 2'b00) begin
                        e_inst = 32'h0000_0013;
                        e_err  = 2'b10;
                    end else begin
                        e_inst = mem_data(m_pc);
                        e_err  = {1'b0, mem_err(m_pc)};
                    end
                    if (out_inst == 32'hDEAD_BEEF) seen_deadbeef = 1;
                    check("out_pc", out_pc, m_pc);
                    check("out_inst", out_inst, e_inst);
                    check("out_err", 32'(out_err), 32'(e_err));
                end else begin
                    idle++;
                    if (idle > 300) begin
                        check("watchdog_out_valid", 32'(out_valid), 32'd1);
                        idle = 0;
                    end
                end
                if (out_valid && out_ready) begin
                    hs_pc.push_back(out_pc);
                    hs_inst.push_back(out_inst);
                    hs_err.push_back(out_err);
                    hs_cyc.push_back(cyc);
                    hs_n++;
                end
                if (redirect_valid) m_pc = redirect_pc;
                else if (out_valid && out_ready) m_pc = m_pc + 32'd4;
                p_ov = out_valid;
                p_or = out_ready;
                p_rd = redirect_valid;
            end
            p_rst = rst_n;
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_hs(input int target, input int bound, input string name);
        int n = 0;
        while (hs_n < target && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hs_n < target) check(name, 32'(hs_n), 32'(target));
    endtask

    task automatic set_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
    endtask

    initial begin
        int base;
        int base_f;
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // Back-to-back fetches, zero-wait memory
        ready_force = 1; lat_lo = 0; lat_hi = 0; out_ready = 1'b1;
        do_reset();
        base = hs_n;
        wait_hs(base + 3, 40, "t1_timeout");
        check("t1_pc0", hs_pc[base], 32'h8000_0000);
        check("t1_pc1", hs_pc[base + 1], 32'h8000_0004);
        check("t1_pc2", hs_pc[base + 2], 32'h8000_0008);
        check("t1_inst0", hs_inst[base], 32'h9234_5678);
        check("t1_inst1", hs_inst[base + 1], 32'h9234_567C);
        check("t1_inst2", hs_inst[base + 2], 32'h9234_5670);
        check("t1_first_latency", 32'(hs_cyc[base] - rel_cyc), 32'd2);
        check("t1_cpi_a", 32'(hs_cyc[base + 1] - hs_cyc[base]), 32'd3);
        check("t1_cpi_b", 32'(hs_cyc[base + 2] - hs_cyc[base + 1]), 32'd3);

        // Memory stall then IDU stall
        ready_force = 0; out_ready = 1'b0;
        do_reset();
        base = hs_n; base_f = fire_n;
        repeat (4) @(posedge clk);
        #1;
        check("t2_no_fire_while_stalled", 32'(fire_n - base_f), 32'd0);
        ready_force = 1;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("t2_reach_hold", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t2_no_hs_while_stalled", 32'(hs_n - base), 32'd0);
        out_ready = 1'b1;
        wait_hs(base + 2, 30, "t2_timeout");
        check("t2_pc0", hs_pc[base], 32'h8000_0000);
        check("t2_pc1", hs_pc[base + 1], 32'h8000_0004);
        check("t2_fire_count", 32'(fire_n - base_f), 32'd2);

        // Redirect while waiting: the stale response must vanish
        ready_force = 1; lat_lo = 2; lat_hi = 2; out_ready = 1'b1;
        do_reset();
        base = hs_n; base_f = fire_n;
        @(posedge clk);
        #1;
        ovr = 1;
        set_redirect(32'h8000_0100);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_hs(base + 1, 40, "t3_timeout");
        check("t3_pc", hs_pc[base], 32'h8000_0100);
        check("t3_inst", hs_inst[base], 32'h9234_5778);
        check("t3_fire_addr", fire_addr[base_f + 1], 32'h8000_0100);
        check("t3_no_deadbeef", 32'(seen_deadbeef), 32'd0);

        // Redirect in HOLD with out_ready high
        lat_lo = 0; lat_hi = 0;
        do_reset();
        base = hs_n; base_f = fire_n;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("t4_reach_hold", 32'(out_valid), 32'd1);
        set_redirect(32'h8000_0200);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("t4_valid_falls", 32'(out_valid), 32'd0);
        wait_hs(base + 2, 30, "t4_timeout");
        check("t4_pc0", hs_pc[base], 32'h8000_0000);
        check("t4_pc1", hs_pc[base + 1], 32'h8000_0200);
        check("t4_inst1", hs_inst[base + 1], 32'h9234_5478);
        check("t4_fire_addr", fire_addr[base_f + 1], 32'h8000_0200);

        // Two redirects while waiting: the last target is fetched
        lat_lo = 2; lat_hi = 2;
        do_reset();
        base = hs_n; base_f = fire_n;
        @(posedge clk);
        #1;
        set_redirect(32'h8000_0300);
        @(posedge clk);
        #1;
        set_redirect(32'h8000_0400);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_hs(base + 1, 40, "t4b_timeout");
        check("t4b_pc", hs_pc[base], 32'h8000_0400);
        check("t4b_fire_addr", fire_addr[base_f + 1], 32'h8000_0400);
        check("t4b_fire_count", 32'(fire_n - base_f), 32'd2);

        // Misaligned redirect target
        ready_force = 0; lat_lo = 0; lat_hi = 0;
        do_reset();
        base = hs_n; base_f = fire_n;
        set_redirect(32'h8000_0102);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        ready_force = 1;
        wait_hs(base + 1, 20, "t5_timeout");
        check("t5_pc", hs_pc[base], 32'h8000_0102);
        check("t5_inst", hs_inst[base], 32'h0000_0013);
        check("t5_err", 32'(hs_err[base]), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_fire", 32'(fire_n - base_f), 32'd0);

        // Access fault on one fetch only
        err_mode = 1; err_addr = 32'h8000_0004;
        do_reset();
        base = hs_n;
        wait_hs(base + 3, 40, "t6_timeout");
        check("t6_err0", 32'(hs_err[base]), 32'd0);
        check("t6_err1", 32'(hs_err[base + 1]), 32'd1);
        check("t6_err2", 32'(hs_err[base + 2]), 32'd0);
        check("t6_pc1", hs_pc[base + 1], 32'h8000_0004);
        err_mode = 0;

        // Randomized traffic
        rand_ready = 1; lat_lo = 0; lat_hi = 2; stray_en = 1; rand_err = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                set_redirect(32'h8000_0000 + ($urandom_range(0, 63) << 2) +
                             (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
            end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                redirect_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        check("rand_no_deadbeef", 32'(seen_deadbeef), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
